// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types: response codes, FSM state encodings and address-to-register index decode.
// Pure declarations; no timing or flow control lives here.
package axi4l_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi4l_resp_t;

    localparam int AXI4L_PROT_PRIV_BIT = 0;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_COMMIT = 2'd1,
        WR_RESP   = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Drops the byte-offset bits; the caller range-checks against the register count.
    function automatic logic [31:0] addr_to_index(input logic [31:0] addr, input int data_width);
        return addr >> $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bus bundle with master and slave views.
// Standard valid/ready handshakes on all five channels.
interface axi4l_if
    import axi4l_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi4l_reg_bank.sv
// Register storage with a byte-strobed write port, combinational read port and per-register commit pulse.
// Write lands on the enabling edge; wr_pulse_o is high for the following cycle; no backpressure.
module axi4l_reg_bank
    import axi4l_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REGS   = 16,
    localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [DATA_WIDTH-1:0]          wr_dat,
    input  logic [STRB_W-1:0]              wr_strb,
    input  logic [IDX_W-1:0]               rd_idx,
    output logic [DATA_WIDTH-1:0]          rd_dat,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   pulse_q;
    logic [NUM_REGS-1:0]   pulse_d;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i]  = regs_q[i];
            pulse_d[i] = wr_en && (wr_idx == IDX_W'(i));
            for (int b = 0; b < STRB_W; b++) begin
                if (pulse_d[i] && wr_strb[b]) begin
                    regs_d[i][b*8 +: 8] = wr_dat[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    assign rd_dat     = (32'(rd_idx) < NUM_REGS) ? regs_q[rd_idx] : '0;
    assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite register slave; AW/W handshake at edge N commits at N+1, one write and one read outstanding.
// Define AXI4L_REG_SLAVE_PROT_CHECK_EN to reject unprivileged accesses with SLVERR.
module axi4l_reg_slave
    import axi4l_pkg::*;
#(
    parameter  int ADDR_WIDTH = 12,
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REGS   = 16,
    localparam int STRB_W     = DATA_WIDTH / 8,
    localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    axi4l_if.slave                         s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);
    wr_state_t             wr_state_q, wr_state_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    axi4l_resp_t           bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [2:0]            awprot_q, awprot_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;

    rd_state_t             rd_state_q, rd_state_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d;
    axi4l_resp_t           rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [31:0]           wr_idx_full, rd_idx_full;
    logic                  wr_err, rd_err, commit;
    logic [DATA_WIDTH-1:0] bank_rdat;

    assign wr_idx_full = addr_to_index(32'(awaddr_q), DATA_WIDTH);
    assign rd_idx_full = addr_to_index(32'(s_axi.araddr), DATA_WIDTH);

`ifdef AXI4L_REG_SLAVE_PROT_CHECK_EN
    assign wr_err = (wr_idx_full >= 32'(NUM_REGS)) || !awprot_q[AXI4L_PROT_PRIV_BIT];
    assign rd_err = (rd_idx_full >= 32'(NUM_REGS)) || !s_axi.arprot[AXI4L_PROT_PRIV_BIT];
`else
    assign wr_err = (wr_idx_full >= 32'(NUM_REGS));
    assign rd_err = (rd_idx_full >= 32'(NUM_REGS));
    logic unused_prot;
    assign unused_prot = ^{awprot_q, s_axi.arprot};
`endif

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        awaddr_d   = awaddr_q;
        awprot_d   = awprot_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        commit     = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (s_axi.awvalid && awready_q) begin
                    awaddr_d  = s_axi.awaddr;
                    awprot_d  = s_axi.awprot;
                    aw_held_d = 1'b1;
                end
                if (s_axi.wvalid && wready_q) begin
                    wdata_d  = s_axi.wdata;
                    wstrb_d  = s_axi.wstrb;
                    w_held_d = 1'b1;
                end
                awready_d = !aw_held_d;
                wready_d  = !w_held_d;
                if (aw_held_d && w_held_d) begin
                    wr_state_d = WR_COMMIT;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                end
            end
            WR_COMMIT: begin
                commit     = 1'b1;
                bresp_d    = wr_err ? SLVERR : OKAY;
                bvalid_d   = 1'b1;
                aw_held_d  = 1'b0;
                w_held_d   = 1'b0;
                wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                if (s_axi.bready) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // The read samples the bank before this edge's commit lands, so same-edge reads see old data.
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (s_axi.arvalid && arready_q) begin
                    rdata_d    = rd_err ? '0 : bank_rdat;
                    rresp_d    = rd_err ? SLVERR : OKAY;
                    rvalid_d   = 1'b1;
                    arready_d  = 1'b0;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (s_axi.rready) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= WR_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            awaddr_q   <= '0;
            awprot_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rresp_q    <= OKAY;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            awaddr_q   <= awaddr_d;
            awprot_q   <= awprot_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    axi4l_reg_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_bank (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .wr_en      (commit && !wr_err),
        .wr_idx     (wr_idx_full[IDX_W-1:0]),
        .wr_dat     (wdata_q),
        .wr_strb    (wstrb_q),
        .rd_idx     (rd_idx_full[IDX_W-1:0]),
        .rd_dat     (bank_rdat),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// Directed bench for axi4l_reg_slave: vector table of write/read pairs plus hand-built handshake corner sequences.
module tb_axi4l_reg_slave;
    import axi4l_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NR = 16;

    logic aclk    = 1'b0;
    logic aresetn = 1'b1;

    axi4l_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    logic [NR*DW-1:0] regs_o;
    logic [NR-1:0]    wr_pulse_o;

    axi4l_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_axi      (bus),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    always #5 aclk = ~aclk;

    int passed = 0;
    int total  = 0;
    logic [DW-1:0] model [NR];
    int pulse_seen [NR] = '{default: 0};

    always @(negedge aclk) begin
        for (int i = 0; i < NR; i++) begin
            if (wr_pulse_o[i]) pulse_seen[i]++;
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdat;
        logic [3:0]    strb;
        logic [1:0]    exp_b;
        logic [1:0]    exp_r;
        logic [DW-1:0] exp_rd;
        int            exp_pulses;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("%s_reg%0d", tag, i), 64'(regs_o[i*DW +: DW]), 64'(model[i]));
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic int pulse_sum();
        int s = 0;
        for (int i = 0; i < NR; i++) s += pulse_seen[i];
        return s;
    endfunction

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                             input logic [2:0] p, output logic [1:0] resp);
        bit aw_hs, w_hs, b_hs;
        bit b_done = 1'b0;
        resp = 2'b11;
        bus.awaddr = a; bus.awprot = p; bus.awvalid = 1'b1;
        bus.wdata  = d; bus.wstrb  = s; bus.wvalid  = 1'b1;
        bus.bready = 1'b1;
        for (int c = 0; c < 40 && !b_done; c++) begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            b_hs  = bus.bvalid && bus.bready;
            if (b_hs) resp = bus.bresp;
            step();
            if (aw_hs) bus.awvalid = 1'b0;
            if (w_hs)  bus.wvalid  = 1'b0;
            if (b_hs)  b_done      = 1'b1;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        check($sformatf("wr_done_%0h", a), 64'(b_done), 64'd1);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input logic [2:0] p,
                            output logic [DW-1:0] d, output logic [1:0] resp);
        bit ar_hs, r_hs;
        bit r_done = 1'b0;
        d = 'x; resp = 2'b11;
        bus.araddr = a; bus.arprot = p; bus.arvalid = 1'b1; bus.rready = 1'b1;
        for (int c = 0; c < 40 && !r_done; c++) begin
            ar_hs = bus.arvalid && bus.arready;
            r_hs  = bus.rvalid && bus.rready;
            if (r_hs) begin d = bus.rdata; resp = bus.rresp; end
            step();
            if (ar_hs) bus.arvalid = 1'b0;
            if (r_hs)  r_done      = 1'b1;
        end
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        check($sformatf("rd_done_%0h", a), 64'(r_done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    br, rr;
        logic [DW-1:0] rd;
        bit            ok;
        int            tgt, sum0, tgt0;

        vecs[0] = '{12'h008, 32'hDEADBEEF, 4'hF, 2'b00, 2'b00, 32'hDEADBEEF, 1};
        vecs[1] = '{12'h00C, 32'h11223344, 4'hF, 2'b00, 2'b00, 32'h11223344, 1};
        vecs[2] = '{12'h00C, 32'hAABBCCDD, 4'h5, 2'b00, 2'b00, 32'h11BB33DD, 1};
        vecs[3] = '{12'h00E, 32'h00000000, 4'h0, 2'b00, 2'b00, 32'h11BB33DD, -1};
        vecs[4] = '{12'h03D, 32'h12345678, 4'h8, 2'b00, 2'b00, 32'h12000000, 1};
        vecs[5] = '{12'h040, 32'hFFFFFFFF, 4'hF, 2'b10, 2'b10, 32'h00000000, 0};
        vecs[6] = '{12'hFFC, 32'h5A5A5A5A, 4'hF, 2'b10, 2'b10, 32'h00000000, 0};
        vecs[7] = '{12'h001, 32'hCAFEF00D, 4'h3, 2'b00, 2'b00, 32'h0000F00D, 1};
        for (int i = 0; i < NR; i++) model[i] = '0;

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        #1 aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("rst_awready", 64'(bus.awready), 64'd1);
        check("rst_wready",  64'(bus.wready),  64'd1);
        check("rst_arready", 64'(bus.arready), 64'd1);
        check("rst_bvalid",  64'(bus.bvalid),  64'd0);
        check("rst_rvalid",  64'(bus.rvalid),  64'd0);
        check("rst_bresp",   64'(bus.bresp),   64'd0);
        check("rst_rresp",   64'(bus.rresp),   64'd0);
        check("rst_rdata",   64'(bus.rdata),   64'd0);
        check("rst_pulse",   64'(wr_pulse_o),  64'd0);
        check_regs("rst");
        aresetn = 1'b1;
        step();

        for (int v = 0; v < 8; v++) begin
            tgt  = int'(vecs[v].addr >> 2);
            sum0 = pulse_sum();
            tgt0 = (tgt < NR) ? pulse_seen[tgt] : 0;
            axi_write(vecs[v].addr, vecs[v].wdat, vecs[v].strb, 3'b001, br);
            axi_read(vecs[v].addr, 3'b001, rd, rr);
            check($sformatf("v%0d_bresp", v), 64'(br), 64'(vecs[v].exp_b));
            check($sformatf("v%0d_rresp", v), 64'(rr), 64'(vecs[v].exp_r));
            check($sformatf("v%0d_rdata", v), 64'(rd), 64'(vecs[v].exp_rd));
            if (vecs[v].exp_b == 2'b00) begin
                for (int b = 0; b < 4; b++) begin
                    if (vecs[v].strb[b]) model[tgt][b*8 +: 8] = vecs[v].wdat[b*8 +: 8];
                end
            end
            if (vecs[v].exp_pulses >= 0) begin
                check($sformatf("v%0d_pulses", v), 64'(pulse_sum() - sum0), 64'(vecs[v].exp_pulses));
                if (vecs[v].exp_pulses == 1)
                    check($sformatf("v%0d_pulse_tgt", v), 64'(pulse_seen[tgt] - tgt0), 64'd1);
            end
            check_regs($sformatf("v%0d", v));
        end

        // W five cycles ahead of AW
        bus.wdata = 32'h01020304; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        check("a_wready_pre", 64'(bus.wready), 64'd1);
        step();
        bus.wvalid = 1'b0;
        check("a_wready_drop", 64'(bus.wready), 64'd0);
        check("a_awready_hold", 64'(bus.awready), 64'd1);
        repeat (4) step();
        bus.awaddr = 12'h004; bus.awprot = 3'b001; bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        check("a_awready_drop", 64'(bus.awready), 64'd0);
        check("a_bvalid_early", 64'(bus.bvalid), 64'd0);
        step();
        check("a_bvalid", 64'(bus.bvalid), 64'd1);
        check("a_bresp", 64'(bus.bresp), 64'd0);
        check("a_pulse", 64'(wr_pulse_o), 64'h0002);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("a_bvalid_clr", 64'(bus.bvalid), 64'd0);
        check("a_ready_back", 64'({bus.awready, bus.wready}), 64'd3);
        step();
        check("a_single_b", 64'(bus.bvalid), 64'd0);
        model[1] = 32'h01020304;

        // AW five cycles ahead of W
        bus.awaddr = 12'h004; bus.awprot = 3'b001; bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        check("b_awready_drop", 64'(bus.awready), 64'd0);
        check("b_wready_hold", 64'(bus.wready), 64'd1);
        repeat (4) step();
        bus.wdata = 32'h0A0B0C0D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        check("b_wready_drop", 64'(bus.wready), 64'd0);
        check("b_bvalid_early", 64'(bus.bvalid), 64'd0);
        step();
        check("b_bvalid", 64'(bus.bvalid), 64'd1);
        check("b_bresp", 64'(bus.bresp), 64'd0);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("b_bvalid_clr", 64'(bus.bvalid), 64'd0);
        step();
        check("b_single_b", 64'(bus.bvalid), 64'd0);
        model[1] = 32'h0A0B0C0D;
        check("b_reg1", 64'(regs_o[1*DW +: DW]), 64'(model[1]));

        // bready held low while a second write waits
        bus.awaddr = 12'h010; bus.awprot = 3'b001; bus.awvalid = 1'b1;
        bus.wdata = 32'h44444444; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        step();
        bus.awaddr = 12'h014; bus.wdata = 32'h55555555; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(bus.bvalid && bus.bresp == 2'b00 && !bus.awready && !bus.wready)) ok = 1'b0;
            step();
        end
        check("c_b_stable", 64'(ok), 64'd1);
        check("c_no_accept", 64'(regs_o[5*DW +: DW]), 64'(model[5]));
        bus.bready = 1'b1;
        step();
        check("c_bvalid_clr", 64'(bus.bvalid), 64'd0);
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("c_awready_2nd", 64'(bus.awready), 64'd0);
        step();
        check("c_bvalid_2nd", 64'(bus.bvalid), 64'd1);
        step();
        bus.bready = 1'b0;
        check("c_bvalid_clr2", 64'(bus.bvalid), 64'd0);
        model[4] = 32'h44444444;
        model[5] = 32'h55555555;
        check_regs("c");

        // rready held low while the register changes underneath
        bus.araddr = 12'h010; bus.arprot = 3'b001; bus.arvalid = 1'b1;
        step();
        bus.arvalid = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(bus.rvalid && bus.rdata == 32'h44444444 && bus.rresp == 2'b00 && !bus.arready)) ok = 1'b0;
            step();
        end
        check("d_r_stable", 64'(ok), 64'd1);
        axi_write(12'h010, 32'h99999999, 4'hF, 3'b001, br);
        model[4] = 32'h99999999;
        check("d_rdata_held", 64'(bus.rdata), 64'h44444444);
        check("d_rvalid_held", 64'(bus.rvalid), 64'd1);
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        check("d_rvalid_clr", 64'(bus.rvalid), 64'd0);
        check("d_arready_back", 64'(bus.arready), 64'd1);

        // read handshaking on the commit edge of the same register
        axi_write(12'h018, 32'h66666666, 4'hF, 3'b001, br);
        bus.awaddr = 12'h018; bus.awprot = 3'b001; bus.awvalid = 1'b1;
        bus.wdata = 32'h77777777; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 12'h018; bus.arprot = 3'b001; bus.arvalid = 1'b1;
        step();
        bus.arvalid = 1'b0;
        check("e_rdata_old", 64'(bus.rdata), 64'h66666666);
        check("e_both_valid", 64'({bus.bvalid, bus.rvalid}), 64'd3);
        check("e_reg6_new", 64'(regs_o[6*DW +: DW]), 64'h77777777);
        bus.bready = 1'b1; bus.rready = 1'b1;
        step();
        bus.bready = 1'b0; bus.rready = 1'b0;
        check("e_both_clr", 64'({bus.bvalid, bus.rvalid}), 64'd0);
        axi_read(12'h018, 3'b001, rd, rr);
        check("e_rdata_new", 64'(rd), 64'h77777777);

        // reset while write sits in WR_RESP and read in RD_DATA
        bus.awaddr = 12'h01C; bus.awprot = 3'b001; bus.awvalid = 1'b1;
        bus.wdata = 32'h12121212; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 12'h008; bus.arprot = 3'b001; bus.arvalid = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        step();
        check("f_pre_valids", 64'({bus.bvalid, bus.rvalid}), 64'd3);
        #2 aresetn = 1'b0;
        #1;
        check("f_valids", 64'({bus.bvalid, bus.rvalid}), 64'd0);
        check("f_readys", 64'({bus.awready, bus.wready, bus.arready}), 64'd7);
        check("f_resps", 64'({bus.bresp, bus.rresp}), 64'd0);
        check("f_rdata", 64'(bus.rdata), 64'd0);
        check("f_pulse", 64'(wr_pulse_o), 64'd0);
        for (int i = 0; i < NR; i++) model[i] = '0;
        check_regs("f");
        @(negedge aclk);
        aresetn = 1'b1;
        step();
        axi_write(12'h01C, 32'hABCD1234, 4'hF, 3'b001, br);
        check("f_post_bresp", 64'(br), 64'd0);
        axi_read(12'h01C, 3'b001, rd, rr);
        check("f_post_rdata", 64'(rd), 64'hABCD1234);
        check("f_post_rresp", 64'(rr), 64'd0);
        model[7] = 32'hABCD1234;

`ifdef AXI4L_REG_SLAVE_PROT_CHECK_EN
        axi_write(12'h000, 32'h12345678, 4'hF, 3'b000, br);
        check("p_bresp", 64'(br), 64'd2);
        check("p_reg0", 64'(regs_o[0 +: DW]), 64'(model[0]));
        axi_read(12'h01C, 3'b000, rd, rr);
        check("p_rresp", 64'(rr), 64'd2);
        check("p_rdata", 64'(rd), 64'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
